// File: rtl/mem2io_seq_if.sv
`timescale 1ns/1ps
// Purpose: CPU request, board I/O and SRAM pin bundle for mem2io_seq.
// Latency: none of its own; wires only.
// Backpressure: none; the sequencer ignores Req while an access is in flight.
interface mem2io_seq_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              Req;
    logic              Wr;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_from_CPU;
    logic [DATA_W-1:0] Data_to_CPU;
    logic              Ready;
    logic [DATA_W-1:0] Switches;
    logic [DATA_W-1:0] HEX;
    logic [DATA_W-1:0] LED;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_OE;
    logic              SRAM_WE;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic [DATA_W-1:0] Data_to_SRAM;

    // Environment side: CPU, board switches and the SRAM data pins.
    modport master (
        output Req, Wr, ADDR, Data_from_CPU, Switches, Data_from_SRAM,
        input  Data_to_CPU, Ready, HEX, LED, SRAM_ADDR, SRAM_OE, SRAM_WE, Data_to_SRAM
    );

    // Sequencer side.
    modport slave (
        input  Req, Wr, ADDR, Data_from_CPU, Switches, Data_from_SRAM,
        output Data_to_CPU, Ready, HEX, LED, SRAM_ADDR, SRAM_OE, SRAM_WE, Data_to_SRAM
    );
endinterface

// File: rtl/mem2io_seq.sv
`timescale 1ns/1ps
// Purpose: sequences single CPU accesses to memory-mapped HEX/LED/Switches or an async SRAM.
// Latency: accept edge to Ready high is 2 cycles for I/O, WAIT_CYC+1 cycles for SRAM.
// Backpressure: none; Req is sampled only in IDLE and ignored otherwise (no queueing).
module mem2io_seq #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    mem2io_seq_if.slave   io_bus
);

    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
        $error("mem2io_seq: WAIT_CYC must be in the range 1..15");
    end

    localparam int CNT_W = $clog2(WAIT_CYC + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_IO   = 2'd1;
    localparam logic [1:0] S_SRAM = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] ADDR_SW_HEX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_LED    = {{(ADDR_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0]  CNT_LOAD    = CNT_W'(WAIT_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdat;
    logic [DATA_W-1:0] r_dcpu;
    logic              r_ready;
    logic [DATA_W-1:0] r_hex;
    logic [DATA_W-1:0] r_led;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [DATA_W-1:0] r_sram_wdat;
    logic              r_oe;
    logic              r_we;

    logic w_is_io;
    logic w_accept;
    logic w_sram_last;
    logic w_cap_hex;

    assign w_is_io     = (io_bus.ADDR == ADDR_SW_HEX) || (io_bus.ADDR == ADDR_LED);
    assign w_accept    = (r_state == S_IDLE) && io_bus.Req;
    assign w_sram_last = (r_state == S_SRAM) && (r_cnt == CNT_LAST);
    assign w_cap_hex   = (r_addr == ADDR_SW_HEX);

    // Access FSM: capture the request in IDLE, then run the I/O or SRAM phase, then DONE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_wdat  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.Req) begin
                        r_addr <= io_bus.ADDR;
                        r_wr   <= io_bus.Wr;
                        r_wdat <= io_bus.Data_from_CPU;
                        if (w_is_io) begin
                            r_state <= S_IO;
                        end else begin
                            r_state <= S_SRAM;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                S_IO:   r_state <= S_DONE;
                S_SRAM: begin
                    r_cnt <= r_cnt - CNT_LAST;
                    if (r_cnt == CNT_LAST) r_state <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // SRAM pins: strobes are registered so they are glitch-free and span exactly the SRAM phase.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sram_addr <= '0;
            r_sram_wdat <= '0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
        end else if (w_accept && !w_is_io) begin
            r_sram_addr <= io_bus.ADDR;
            r_oe        <= !io_bus.Wr;
            r_we        <= io_bus.Wr;
            if (io_bus.Wr) r_sram_wdat <= io_bus.Data_from_CPU;
        end else if (w_sram_last) begin
            r_oe <= 1'b0;
            r_we <= 1'b0;
        end
    end

    // Read data and display registers: updated only when an access actually completes its work.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_dcpu <= '0;
            r_hex  <= '0;
            r_led  <= '0;
        end else if (r_state == S_IO) begin
            if (r_wr) begin
                if (w_cap_hex) r_hex <= r_wdat;
                else           r_led <= r_wdat;
            end else begin
                r_dcpu <= w_cap_hex ? io_bus.Switches : r_led;
            end
        end else if (w_sram_last && !r_wr) begin
            r_dcpu <= io_bus.Data_from_SRAM;
        end
    end

    // Completion pulse: one cycle, issued on the way out of DONE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_ready <= 1'b0;
        else        r_ready <= (r_state == S_DONE);
    end

    assign io_bus.Data_to_CPU  = r_dcpu;
    assign io_bus.Ready        = r_ready;
    assign io_bus.HEX          = r_hex;
    assign io_bus.LED          = r_led;
    assign io_bus.SRAM_ADDR    = r_sram_addr;
    assign io_bus.SRAM_OE      = r_oe;
    assign io_bus.SRAM_WE      = r_we;
    assign io_bus.Data_to_SRAM = r_sram_wdat;

endmodule

// File: tb/tb_mem2io_seq.sv
`timescale 1ns/1ps
// Purpose: randomized and directed bench for mem2io_seq against a transaction-timeline model.
// Latency: model predicts each output per cycle from edges elapsed since accept.
// Backpressure: bench only issues directed requests when the sequencer is idle.
module tb_mem2io_seq;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int W  = 2;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    mem2io_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem2io_seq #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .io_bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: an access is a timeline counted in edges since its accept edge.
    logic [15:0] m_dcpu  = '0, m_hex = '0, m_led = '0, m_saddr = '0, m_swdat = '0;
    logic [15:0] m_addr  = '0, m_wdat = '0;
    logic        m_ready = 1'b0, m_active = 1'b0, m_io = 1'b0, m_wr = 1'b0;
    int          m_k     = 0;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_dcpu = '0; m_hex = '0; m_led = '0; m_saddr = '0; m_swdat = '0;
            m_ready = 1'b0; m_active = 1'b0; m_k = 0;
        end else begin
            m_ready = 1'b0;
            if (m_active) begin
                m_k++;
                if (m_io && m_k == 1) begin
                    if (m_wr) begin
                        if (m_addr == 16'hFFFF) m_hex = m_wdat;
                        else                    m_led = m_wdat;
                    end else begin
                        m_dcpu = (m_addr == 16'hFFFF) ? bus.Switches : m_led;
                    end
                end
                if (!m_io && !m_wr && m_k == W) m_dcpu = bus.Data_from_SRAM;
                if (m_k == (m_io ? 2 : W + 1)) begin
                    m_ready  = 1'b1;
                    m_active = 1'b0;
                end
            end else if (bus.Req) begin
                m_active = 1'b1;
                m_k      = 0;
                m_addr   = bus.ADDR;
                m_wr     = bus.Wr;
                m_wdat   = bus.Data_from_CPU;
                m_io     = (bus.ADDR == 16'hFFFF) || (bus.ADDR == 16'hFFFE);
                if (!m_io) begin
                    m_saddr = bus.ADDR;
                    if (bus.Wr) m_swdat = bus.Data_from_CPU;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge Clk) begin
        chk("data_to_cpu",  32'(bus.Data_to_CPU),  32'(m_dcpu));
        chk("ready",        32'(bus.Ready),        32'(m_ready));
        chk("hex",          32'(bus.HEX),          32'(m_hex));
        chk("led",          32'(bus.LED),          32'(m_led));
        chk("sram_addr",    32'(bus.SRAM_ADDR),    32'(m_saddr));
        chk("data_to_sram", 32'(bus.Data_to_SRAM), 32'(m_swdat));
        chk("sram_oe", 32'(bus.SRAM_OE), 32'(m_active && !m_io && !m_wr && m_k < W));
        chk("sram_we", 32'(bus.SRAM_WE), 32'(m_active && !m_io &&  m_wr && m_k < W));
    end

    // Caller is at a negedge with the sequencer idle; returns at the negedge where Ready is seen.
    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          output int lat, output int oe_n, output int we_n);
        int acc;
        bus.Req = 1'b1; bus.Wr = wr; bus.ADDR = addr; bus.Data_from_CPU = wd;
        @(posedge Clk); #1;
        acc = cyc;
        lat = -1; oe_n = 0; we_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (i == 0) begin
                bus.Req = 1'b0;
                bus.Wr = 1'($urandom);
                bus.ADDR = 16'($urandom);
                bus.Data_from_CPU = 16'($urandom);
            end
            if (bus.SRAM_OE) oe_n++;
            if (bus.SRAM_WE) we_n++;
            if (bus.Ready) begin
                lat = cyc - acc;
                break;
            end
        end
    endtask

    initial begin
        int lat, oe_n, we_n, n, rdy_n;
        int t[3];
        logic rst_pend;

        // Reset held low with random activity on every input.
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            bus.Req = 1'($urandom); bus.Wr = 1'($urandom);
            bus.ADDR = 16'($urandom); bus.Data_from_CPU = 16'($urandom);
            bus.Switches = 16'($urandom); bus.Data_from_SRAM = 16'($urandom);
        end
        chk("rst_dcpu", 32'(bus.Data_to_CPU), 0);
        chk("rst_ready", 32'(bus.Ready), 0);
        chk("rst_hex", 32'(bus.HEX), 0);
        chk("rst_led", 32'(bus.LED), 0);
        chk("rst_oe_we", 32'({bus.SRAM_OE, bus.SRAM_WE}), 0);
        chk("rst_saddr", 32'(bus.SRAM_ADDR), 0);
        bus.Req = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);

        // SRAM read.
        bus.Data_from_SRAM = 16'hBEEF;
        access(1'b0, 16'h0040, 16'h0000, lat, oe_n, we_n);
        chk("rd_lat", 32'(lat), 3);
        chk("rd_oe_cycles", 32'(oe_n), 2);
        chk("rd_we_cycles", 32'(we_n), 0);
        chk("rd_data", 32'(bus.Data_to_CPU), 32'h0000BEEF);

        // SRAM write; address and data hold afterwards.
        access(1'b1, 16'h0010, 16'h1234, lat, oe_n, we_n);
        chk("wr_lat", 32'(lat), 3);
        chk("wr_we_cycles", 32'(we_n), 2);
        chk("wr_oe_cycles", 32'(oe_n), 0);
        chk("wr_saddr", 32'(bus.SRAM_ADDR), 32'h0010);
        chk("wr_sdat", 32'(bus.Data_to_SRAM), 32'h1234);

        // I/O writes.
        access(1'b1, 16'hFFFF, 16'hA5C3, lat, oe_n, we_n);
        chk("hexw_lat", 32'(lat), 2);
        chk("hexw_strobes", 32'(oe_n + we_n), 0);
        access(1'b1, 16'hFFFE, 16'h00FF, lat, oe_n, we_n);
        chk("ledw_lat", 32'(lat), 2);
        chk("ledw_strobes", 32'(oe_n + we_n), 0);
        chk("hex_val", 32'(bus.HEX), 32'hA5C3);
        chk("led_val", 32'(bus.LED), 32'h00FF);
        chk("dcpu_hold", 32'(bus.Data_to_CPU), 32'hBEEF);

        // I/O reads.
        bus.Switches = 16'h0F0F;
        access(1'b0, 16'hFFFF, 16'h0000, lat, oe_n, we_n);
        chk("sw_lat", 32'(lat), 2);
        chk("sw_data", 32'(bus.Data_to_CPU), 32'h0F0F);
        access(1'b0, 16'hFFFE, 16'h0000, lat, oe_n, we_n);
        chk("ledr_data", 32'(bus.Data_to_CPU), 32'h00FF);

        // Req held for three SRAM reads.
        bus.Req = 1'b1; bus.Wr = 1'b0; bus.ADDR = 16'h0040;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge Clk);
            if (bus.Ready) begin
                t[n] = cyc;
                n++;
            end
        end
        bus.Req = 1'b0;
        chk("b2b_count", 32'(n), 3);
        chk("b2b_gap1", 32'(t[1] - t[0]), 4);
        chk("b2b_gap2", 32'(t[2] - t[1]), 4);

        // Reset during the second SRAM cycle of a write.
        @(negedge Clk);
        bus.Req = 1'b1; bus.Wr = 1'b1; bus.ADDR = 16'h0010; bus.Data_from_CPU = 16'h5555;
        @(posedge Clk);
        @(posedge Clk); #2;
        chk("abort_we_before", 32'(bus.SRAM_WE), 1);
        Reset = 1'b0;
        #1;
        chk("abort_we_async", 32'(bus.SRAM_WE), 0);
        chk("abort_oe_async", 32'(bus.SRAM_OE), 0);
        bus.Req = 1'b0;
        rdy_n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (bus.Ready) rdy_n++;
        end
        chk("abort_no_ready", 32'(rdy_n), 0);
        Reset = 1'b1;
        access(1'b0, 16'hFFFF, 16'h0000, lat, oe_n, we_n);
        chk("post_rst_lat", 32'(lat), 2);
        chk("post_rst_data", 32'(bus.Data_to_CPU), 32'h0F0F);

        // Randomized traffic with occasional asynchronous reset pulses.
        rst_pend = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge Clk);
            if (rst_pend) begin
                Reset = 1'b1;
                rst_pend = 1'b0;
            end
            bus.Req = ($urandom_range(0, 3) != 0);
            bus.Wr = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       bus.ADDR = 16'hFFFF;
                1:       bus.ADDR = 16'hFFFE;
                default: bus.ADDR = 16'($urandom);
            endcase
            bus.Data_from_CPU = 16'($urandom);
            bus.Switches = 16'($urandom);
            bus.Data_from_SRAM = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                #2;
                Reset = 1'b0;
                #1;
                chk("rnd_rst_strobes", 32'({bus.SRAM_OE, bus.SRAM_WE}), 0);
                chk("rnd_rst_ready", 32'(bus.Ready), 0);
                rst_pend = 1'b1;
            end
        end
        @(negedge Clk);
        Reset = 1'b1;
        bus.Req = 1'b0;
        repeat (6) @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem2io_seq.md
MEM2IO_SEQ -- requirements
Module: mem2io_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning CPU, SRAM and I/O data width.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning address width.
REQ-003 SHALL have parameter WAIT_CYC, default 2, meaning SRAM access wait cycles; legal range 1..15; any other value SHALL fail elaboration.
REQ-004 SHALL have ports, one per line:
- Clk  in  1  single clock; all flops rising-edge.
- Reset  in  1  asynchronous, active-low reset.
- Req  in  1  CPU access request.
- Wr  in  1  1 = write, 0 = read; sampled with Req.
- ADDR  in  ADDR_W  access address.
- Data_from_CPU  in  DATA_W  write data.
- Data_to_CPU  out  DATA_W  read data, registered.
- Ready  out  1  one-cycle completion pulse.
- Switches  in  DATA_W  board switches.
- HEX  out  DATA_W  hex display register.
- LED  out  DATA_W  LED register.
- SRAM_ADDR  out  ADDR_W  SRAM address.
- SRAM_OE  out  1  SRAM output enable.
- SRAM_WE  out  1  SRAM write enable.
- Data_from_SRAM  in  DATA_W  SRAM read data.
- Data_to_SRAM  out  DATA_W  SRAM write data.

Function
REQ-005 SHALL decode I/O addresses: SW_HEX = all-ones; LED = all-ones minus 1; all other addresses are SRAM.
REQ-006 SHALL implement FSM states IDLE, IO, SRAM, DONE.
REQ-007 In IDLE with Req=1, SHALL capture ADDR, Wr and Data_from_CPU into internal registers. It SHALL then move to IO for I/O addresses and to SRAM otherwise.
REQ-008 Req SHALL be ignored in IO, SRAM and DONE. There is no queuing.
REQ-009 IO is one cycle long, then DONE, with these actions:
- read SW_HEX: latches Switches.
- read LED: latches LED.
- write SW_HEX: loads HEX.
- write LED: loads LED.
REQ-010 SRAM SHALL last exactly WAIT_CYC cycles using a down-counter of width clog2(WAIT_CYC+1).
- SRAM_ADDR SHALL equal the captured address.
- Read: SRAM_OE=1.
- Write: SRAM_WE=1, with Data_to_SRAM equal to the captured data.
REQ-011 On a read, Data_from_SRAM SHALL be latched into Data_to_CPU on the last SRAM cycle.
REQ-012 SRAM_OE and SRAM_WE SHALL be asserted only in SRAM state and never both at once. They SHALL never be asserted for I/O addresses.
REQ-013 DONE SHALL assert Ready for exactly one cycle, then return to IDLE.
REQ-014 Latency from the accept edge to Ready high SHALL be:
- I/O access: 2 cycles.
- SRAM access: WAIT_CYC+1 cycles.
REQ-015 Req held continuously SHALL be accepted again in the IDLE cycle following DONE, so the minimum gap between Ready pulses is latency+1 cycles.
REQ-016 Data_to_CPU SHALL hold its last value across writes and idle cycles.
REQ-017 HEX and LED SHALL change only on completed writes to their addresses.
REQ-018 Outside SRAM state, SRAM_ADDR and Data_to_SRAM SHALL hold their last values; no combinational path from inputs to them.
REQ-019 A change on ADDR, Wr or Data_from_CPU after accept SHALL not affect the access in flight.

Reset
REQ-020 When Reset=0, SHALL asynchronously force the following:
- state IDLE and counter 0.
- Data_to_CPU, HEX, LED, SRAM_ADDR and Data_to_SRAM to 0.
- Ready, SRAM_OE and SRAM_WE to 0.
REQ-021 Reset asserted mid-access SHALL abort the access with no Ready pulse. SRAM_OE/SRAM_WE SHALL drop without waiting for Clk.
REQ-022 After Reset returns to 1, the first Req SHALL be accepted on the next rising edge.

Verification (WAIT_CYC=2, DATA_W=16)
- Reset low, all inputs random -> every output 0; Req ignored while Reset=0.
- Read 16'h0040, Data_from_SRAM=16'hBEEF -> SRAM_OE high 2 cycles, then Ready on cycle 3 with Data_to_CPU=16'hBEEF; SRAM_WE stays 0.
- Write 16'h1234 to 16'h0010 -> SRAM_WE high 2 cycles with Data_to_SRAM=16'h1234 and SRAM_ADDR=16'h0010, then Ready.
- Write 16'hA5C3 to 16'hFFFF, then write 16'h00FF to 16'hFFFE -> HEX=16'hA5C3, LED=16'h00FF, SRAM_OE/SRAM_WE never high, each Ready 2 cycles after accept.
- Read 16'hFFFF with Switches=16'h0F0F -> Data_to_CPU=16'h0F0F at Ready.
- Req held high for 3 SRAM reads -> Ready pulses 4 cycles apart.
- Reset pulsed during the second SRAM cycle of a write -> SRAM_WE drops immediately and there is no Ready.
- Same case, then Req after release -> accepted on the first edge.
